// File: rtl/uart_loader_pkg.sv
// Shared types for the UART word loader: error causes, frame and
// receiver state encodings, default frame markers.
package uart_loader_pkg;

    typedef enum logic [1:0] {
        ERR_END     = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_FRAME   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_CSUM,
        ST_END
    } state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] DEF_START_BYTE = 8'haa;
    localparam logic [7:0] DEF_END_BYTE   = 8'h55;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, half-bit start recheck,
// bit timer and LSB-first shifter. Pulses byte_valid or frame_err.
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int BIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(BIT_CYCLES) + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic            meta_q, sync_q, prev_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            tick;

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            meta_q  <= uart_rxd;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_IDLE:  if (prev_q && !sync_q) state_d = RX_START;
            RX_START: if (tick) state_d = sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_q == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (tick) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        bit_d = bit_q;
        sh_d  = sh_q;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = HALF_M1;
                bit_d = '0;
            end
            RX_DATA: begin
                cnt_d = tick ? FULL_M1 : cnt_q - CNT_ONE;
                if (tick) begin
                    sh_d  = {sync_q, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                end
            end
            default: cnt_d = tick ? FULL_M1 : cnt_q - CNT_ONE;
        endcase
    end

    // Stop-bit sample cycle; returning to idle here re-arms for back-to-back bytes
    assign byte_valid = (state_q == RX_STOP) && tick && sync_q;
    assign frame_err  = (state_q == RX_STOP) && tick && !sync_q;
    assign rx_byte    = sh_q;

endmodule

// File: rtl/uart_word_loader.sv
// Host loader frame decoder: turns AA/addr/data/[csum]/55 frames from the
// UART into one-cycle write strobes, with error pulses and a drop counter.
module uart_word_loader
    import uart_loader_pkg::*;
#(
    parameter int         CLK_HZ       = 50000000,
    parameter int         BAUD_HZ      = 25000000,
    parameter int         ADDR_BYTES   = 4,
    parameter int         DATA_BYTES   = 4,
    parameter int         USE_CHECKSUM = 0,
    parameter int         TIMEOUT_BITS = 32,
    parameter logic [7:0] START_BYTE   = DEF_START_BYTE,
    parameter logic [7:0] END_BYTE     = DEF_END_BYTE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    output logic                    we,
    output logic [8*ADDR_BYTES-1:0] addr,
    output logic [8*DATA_BYTES-1:0] data,
    output logic                    err,
    output logic [1:0]              err_code,
    output logic [7:0]              err_count
);

    localparam int BIT_CYCLES = CLK_HZ / BAUD_HZ;
    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam int TO_CYCLES = TIMEOUT_BITS * BIT_CYCLES;
    localparam int TW = $clog2(TO_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);
    localparam logic [1:0] A_LAST = 2'(ADDR_BYTES - 1);
    localparam logic [1:0] D_LAST = 2'(DATA_BYTES - 1);

    logic [7:0] rx_byte;
    logic       byte_valid, frame_err;

    uart_rx_byte #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .uart_rxd   (uart_rxd),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    state_e          state_q, state_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [AW-1:0]   addr_sh_q, addr_sh_d, addr_q, addr_d;
    logic [DW-1:0]   data_sh_q, data_sh_d, data_q, data_d;
    logic [7:0]      csum_q, csum_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            we_q, we_d, err_q, err_d;
    err_code_e       err_code_q, err_code_d;
    logic [7:0]      err_count_q, err_count_d;
    logic            busy, fe_hit, to_hit, fail;
    err_code_e       fcode;

    assign busy   = (state_q != ST_IDLE);
    assign fe_hit = busy && frame_err;
    // A byte completing on the expiry cycle takes priority
    assign to_hit = busy && !byte_valid && !frame_err
                    && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bcnt_q      <= '0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            csum_q      <= '0;
            to_cnt_q    <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_END;
            err_count_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            csum_q      <= csum_d;
            to_cnt_q    <= to_cnt_d;
            we_q        <= we_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_count_q <= err_count_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fe_hit || to_hit) begin
            state_d = ST_IDLE;
        end else if (byte_valid) begin
            unique case (state_q)
                ST_IDLE: if (rx_byte == START_BYTE) state_d = ST_ADDR;
                ST_ADDR: if (bcnt_q == A_LAST) state_d = ST_DATA;
                ST_DATA: if (bcnt_q == D_LAST)
                    state_d = (USE_CHECKSUM != 0) ? ST_CSUM : ST_END;
                ST_CSUM: state_d = (rx_byte == csum_q) ? ST_END : ST_IDLE;
                ST_END:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bcnt_d      = bcnt_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        csum_d      = csum_q;
        to_cnt_d    = busy ? to_cnt_q + TO_ONE : '0;
        we_d        = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        err_count_d = err_count_q;
        addr_d      = addr_q;
        data_d      = data_q;
        fail        = 1'b0;
        fcode       = ERR_END;
        if (fe_hit) begin
            fail  = 1'b1;
            fcode = ERR_FRAME;
        end else if (to_hit) begin
            fail  = 1'b1;
            fcode = ERR_TIMEOUT;
        end else if (byte_valid) begin
            to_cnt_d = '0;
            unique case (state_q)
                ST_IDLE: if (rx_byte == START_BYTE) begin
                    addr_sh_d = '0;
                    data_sh_d = '0;
                    csum_d    = '0;
                    bcnt_d    = '0;
                end
                ST_ADDR: begin
                    for (int i = 0; i < ADDR_BYTES; i++)
                        if (bcnt_q == 2'(i)) addr_sh_d[8*i +: 8] = rx_byte;
                    csum_d = csum_q ^ rx_byte;
                    bcnt_d = (bcnt_q == A_LAST) ? 2'd0 : bcnt_q + 2'd1;
                end
                ST_DATA: begin
                    for (int i = 0; i < DATA_BYTES; i++)
                        if (bcnt_q == 2'(i)) data_sh_d[8*i +: 8] = rx_byte;
                    csum_d = csum_q ^ rx_byte;
                    bcnt_d = (bcnt_q == D_LAST) ? 2'd0 : bcnt_q + 2'd1;
                end
                ST_CSUM: if (rx_byte != csum_q) begin
                    fail  = 1'b1;
                    fcode = ERR_CSUM;
                end
                ST_END: begin
                    if (rx_byte == END_BYTE) begin
                        we_d   = 1'b1;
                        addr_d = addr_sh_q;
                        data_d = data_sh_q;
                    end else begin
                        fail  = 1'b1;
                        fcode = ERR_END;
                    end
                end
                default: ;
            endcase
        end
        if (fail) begin
            err_d      = 1'b1;
            err_code_d = fcode;
            if (err_count_q != 8'hff) err_count_d = err_count_q + 8'd1;
        end
    end

    assign we        = we_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_count = err_count_q;
    assign addr      = addr_q;
    assign data      = data_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// Self-checking bench: two loader instances (default 32/32 and a 16/8
// checksum variant) driven by a byte-level UART sender and a frame model.
module tb_uart_word_loader;

    localparam int F_NONE = 0;
    localparam int F_END  = 1;
    localparam int F_CSUM = 2;
    localparam int F_STOP = 3;
    localparam int F_TMO  = 4;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd0 = 1'b1, rxd1 = 1'b1;
    logic        we0, err0, we1, err1;
    logic [31:0] addr0, data0;
    logic [15:0] addr1;
    logic [7:0]  data1;
    logic [1:0]  code0, code1;
    logic [7:0]  cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] m_a[2];
    logic [31:0] m_d[2];
    logic [1:0]  m_code[2];
    int          m_cnt[2];

    always #5 clk = ~clk;

    uart_word_loader u0 (
        .clk       (clk),
        .reset     (rst_n),
        .uart_rxd  (rxd0),
        .we        (we0),
        .addr      (addr0),
        .data      (data0),
        .err       (err0),
        .err_code  (code0),
        .err_count (cnt0)
    );

    uart_word_loader #(
        .USE_CHECKSUM (1),
        .ADDR_BYTES   (2),
        .DATA_BYTES   (1)
    ) u1 (
        .clk       (clk),
        .reset     (rst_n),
        .uart_rxd  (rxd1),
        .we        (we1),
        .addr      (addr1),
        .data      (data1),
        .err       (err1),
        .err_code  (code1),
        .err_count (cnt1)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic bit pop(input int ch, output exp_t x);
        x = '{0, 2'd0, 32'd0, 32'd0};
        if (ch == 0) begin
            if (q0.size() == 0) return 1'b0;
            x = q0.pop_front();
        end else begin
            if (q1.size() == 0) return 1'b0;
            x = q1.pop_front();
        end
        return 1'b1;
    endfunction

    task automatic chk(input int ch, input logic w, input logic e,
                       input logic [1:0] code, input logic [7:0] cnt,
                       input logic [31:0] a, input logic [31:0] d);
        exp_t x;
        bit   got;
        if (w) begin
            got = pop(ch, x);
            if (!got || x.is_err) begin
                total++;
                bad++;
                $display("FAIL ch%0d unexpected_we addr=%h data=%h",
                         ch, a, d);
            end else begin
                check($sformatf("ch%0d_we_addr", ch), a, x.a);
                check($sformatf("ch%0d_we_data", ch), d, x.d);
                m_a[ch] = x.a;
                m_d[ch] = x.d;
            end
        end else begin
            check($sformatf("ch%0d_hold_addr", ch), a, m_a[ch]);
            check($sformatf("ch%0d_hold_data", ch), d, m_d[ch]);
        end
        if (e) begin
            got = pop(ch, x);
            if (!got || !x.is_err) begin
                total++;
                bad++;
                $display("FAIL ch%0d unexpected_err code=%0d", ch, code);
            end else begin
                if (m_cnt[ch] < 255) m_cnt[ch]++;
                m_code[ch] = x.code;
                check($sformatf("ch%0d_err_code", ch), 32'(code),
                      32'(x.code));
                check($sformatf("ch%0d_err_count", ch), 32'(cnt),
                      32'(m_cnt[ch]));
            end
        end else begin
            check($sformatf("ch%0d_hold_code", ch), 32'(code),
                  32'(m_code[ch]));
            check($sformatf("ch%0d_hold_count", ch), 32'(cnt),
                  32'(m_cnt[ch]));
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            for (int i = 0; i < 2; i++) begin
                m_a[i]    = '0;
                m_d[i]    = '0;
                m_code[i] = '0;
                m_cnt[i]  = 0;
            end
        end else begin
            chk(0, we0, err0, code0, cnt0, addr0, data0);
            chk(1, we1, err1, code1, cnt1, {16'h0, addr1}, {24'h0, data1});
        end
    end

    task automatic set_line(input int ch, input logic v);
        if (ch == 0) rxd0 = v;
        else rxd1 = v;
    endtask

    task automatic bit_wait();
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input int ch, input logic [7:0] b,
                             input bit bad_stop);
        set_line(ch, 1'b0);
        bit_wait();
        for (int i = 0; i < 8; i++) begin
            set_line(ch, b[i]);
            bit_wait();
        end
        set_line(ch, !bad_stop);
        bit_wait();
        set_line(ch, 1'b1);
    endtask

    function automatic logic [31:0] mask(input int nb);
        return (nb >= 4) ? 32'hffff_ffff : ((32'h1 << (8 * nb)) - 32'h1);
    endfunction

    function automatic logic [1:0] code_of(input int f);
        case (f)
            F_CSUM:  return 2'd1;
            F_STOP:  return 2'd2;
            F_TMO:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic frame(input int ch, input logic [31:0] a,
                         input logic [31:0] d, input int fault);
        int         ab, db;
        logic [7:0] cs, bt;
        exp_t       e;
        ab = (ch == 0) ? 4 : 2;
        db = (ch == 0) ? 4 : 1;
        cs = 8'h00;
        e.is_err = (fault != F_NONE);
        e.code   = code_of(fault);
        e.a      = a & mask(ab);
        e.d      = d & mask(db);
        if (ch == 0) q0.push_back(e);
        else q1.push_back(e);
        send_byte(ch, 8'haa, 1'b0);
        for (int i = 0; i < ab; i++) begin
            bt = a[8*i +: 8];
            cs ^= bt;
            send_byte(ch, bt, 1'b0);
            if (fault == F_TMO && i == 1) begin
                repeat (33) bit_wait();
                return;
            end
        end
        for (int i = 0; i < db; i++) begin
            bt = d[8*i +: 8];
            cs ^= bt;
            if (fault == F_STOP && i == 0) begin
                send_byte(ch, bt, 1'b1);
                repeat (2) bit_wait();
                return;
            end
            send_byte(ch, bt, 1'b0);
        end
        if (ch == 1)
            send_byte(ch, (fault == F_CSUM) ? (cs ^ 8'h01) : cs, 1'b0);
        send_byte(ch, (fault == F_END) ? 8'h56 : 8'h55, 1'b0);
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        check("rst_we", 32'(we0), 32'h0);
        check("rst_err", 32'(err0), 32'h0);
        check("rst_code", 32'(code0), 32'h0);
        check("rst_count", 32'(cnt0), 32'h0);
        check("rst_addr", addr0, 32'h0);
        check("rst_data", data0, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        frame(0, 32'h0000_5000, 32'h0000_0001, F_NONE);
        settle();
        check("f1_addr", addr0, 32'h0000_5000);
        check("f1_data", data0, 32'h0000_0001);
        check("f1_count", 32'(cnt0), 32'h0);

        for (int i = 0; i < 14; i++)
            frame(0, 32'h4000 + 32'(i), 32'(14 - i), F_NONE);
        settle();
        check("b2b_addr", addr0, 32'h0000_400d);
        check("b2b_data", data0, 32'h0000_0001);

        send_byte(0, 8'h12, 1'b0);
        send_byte(0, 8'h34, 1'b0);
        frame(0, 32'hdead_beef, 32'h1234_5678, F_NONE);
        settle();
        check("garb_addr", addr0, 32'hdead_beef);
        check("garb_count", 32'(cnt0), 32'h0);

        frame(1, 32'h1234, 32'h7f, F_NONE);
        settle();
        check("cs_addr", 32'(addr1), 32'h1234);
        check("cs_data", 32'(data1), 32'h7f);
        frame(1, 32'h1234, 32'h7f, F_CSUM);
        settle();
        check("cs_bad_code", 32'(code1), 32'h1);
        check("cs_bad_count", 32'(cnt1), 32'h1);

        frame(0, 32'h0000_1111, 32'h2222_2222, F_END);
        frame(0, 32'h0000_3333, 32'h4444_4444, F_NONE);
        settle();
        check("end_code", 32'(code0), 32'h0);
        check("after_end_addr", addr0, 32'h0000_3333);
        frame(0, 32'h0000_5555, 32'h6666_6666, F_STOP);
        settle();
        check("stop_code", 32'(code0), 32'h2);
        frame(0, 32'h0000_7777, 32'h8888_8888, F_TMO);
        settle();
        check("tmo_code", 32'(code0), 32'h3);
        check("three_errs", 32'(cnt0), 32'h3);
        check("err_hold_addr", addr0, 32'h0000_3333);

        send_byte(0, 8'haa, 1'b0);
        send_byte(0, 8'h01, 1'b0);
        send_byte(0, 8'h02, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_addr", addr0, 32'h0);
        check("mid_rst_data", data0, 32'h0);
        check("mid_rst_count", 32'(cnt0), 32'h0);
        check("mid_rst_we", 32'(we0), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        frame(0, 32'h0000_0abc, 32'h0000_0def, F_NONE);
        settle();
        check("post_rst_addr", addr0, 32'h0000_0abc);
        check("post_rst_data", data0, 32'h0000_0def);

        repeat (20) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_word_loader.md
# uart_word_loader

Receives the host loader protocol directly from the UART RX pin and turns each complete frame into a single-cycle memory or IO write strobe. A frame carries a start marker, an address, a data word, an optional checksum and an end marker. It sits between `uart_rxd` and the SoC write mux, and replaces the fixed 32/32-bit loader with parametrised field widths. It also adds checksum checking, inter-byte timeout and error reporting.

## Interface
- CLK_HZ, 50000000, system clock frequency
- BAUD_HZ, 25000000, UART bit rate; BIT_CYCLES = CLK_HZ / BAUD_HZ, must be ≥ 2
- ADDR_BYTES, 4, address bytes per frame, 1..4
- DATA_BYTES, 4, data bytes per frame, 1..4
- USE_CHECKSUM, 0, 1 inserts an XOR checksum byte before the end marker
- TIMEOUT_BITS, 32, idle bit-times allowed between bytes inside a frame
- START_BYTE, 8'haa, frame start marker
- END_BYTE, 8'h55, frame end marker
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- uart_rxd  input  1  serial input, idle high, asynchronous to clk
- we  output  1  one-cycle write strobe
- addr  output  8*ADDR_BYTES  write address, valid while we=1
- data  output  8*DATA_BYTES  write data, valid while we=1
- err  output  1  one-cycle pulse on any dropped frame
- err_code  output  2  cause of the last err: 0 end marker, 1 checksum, 2 framing, 3 timeout
- err_count  output  8  saturating count of dropped frames

## Operation
- Byte receiver (8N1, LSB first):
  - uart_rxd passes through a 2-flop synchroniser.
  - A falling edge in idle starts a byte. The line is re-checked at BIT_CYCLES/2; if high, the byte is discarded silently as a glitch.
  - Each of the 8 data bits is sampled every BIT_CYCLES after that point.
  - The stop bit is sampled one BIT_CYCLES later. Stop low means a framing error.
- Frame FSM states: IDLE, ADDR, DATA, CSUM, END.
  - IDLE: bytes other than START_BYTE are discarded without error. START_BYTE clears the shift registers and the checksum, then moves to ADDR.
  - ADDR: collects ADDR_BYTES bytes LSB first into addr_sh, then moves to DATA.
  - DATA: collects DATA_BYTES bytes LSB first, then moves to CSUM if USE_CHECKSUM, otherwise to END.
  - CSUM: compares the received byte against the XOR of all address and data bytes. A mismatch raises error 1 and returns to IDLE.
  - END: END_BYTE fires we. Any other byte raises error 0. Both return to IDLE.
- A framing error in any state other than IDLE raises error 2 and returns to IDLE. In IDLE it is ignored.
- Timeout: outside IDLE, a counter resets on each received byte. Reaching TIMEOUT_BITS*BIT_CYCLES cycles raises error 3 and returns to IDLE.
- addr and data outputs hold the last successful frame. They change only on the cycle we rises.
- err_count stops at 255. A new START_BYTE is accepted on the byte immediately following any error.

## Timing
- Reset values: we=0, err=0, err_code=0, err_count=0, addr=0, data=0, FSM in IDLE, receiver idle.
- we and err are registered. Each asserts exactly one cycle, starting the cycle after the END (or failing) byte's stop bit is sampled.
- Latency: 2 sync cycles, then 9.5 bit-times from the start edge to the stop-bit sample, then 1 cycle to the strobe.
- Back-to-back bytes are accepted with zero idle bits between them: the receiver re-arms on the stop-bit sample cycle.
- Simultaneous timeout and byte completion: byte completion wins.
- Reset mid-frame: all state is cleared immediately and no strobe is generated. A frame in flight when reset releases is lost, and the receiver resyncs on the next START_BYTE.

## Structure
- Shared package `uart_loader_pkg`: err_code encodings, FSM state enumeration, default START_BYTE and END_BYTE.
- Sub-module `uart_rx_byte`: synchroniser, bit timer and shifter; outputs byte, byte_valid and frame_err.
- The top module holds the frame FSM, checksum, timeout counter and output registers.

## Test plan
All scenarios use BIT_CYCLES=2 unless stated.
- Defaults, frame AA 00 50 00 00 01 00 00 00 55 → one we pulse, addr=32'h00005000, data=32'h00000001, err never asserted.
- 14 back-to-back frames for addr 0x4000..0x400d → 14 we pulses in order with matching addr/data; last data=32'h00000001.
- Garbage 12 34 AA, then a valid frame → the first two bytes are ignored and one correct we follows.
- USE_CHECKSUM=1, ADDR_BYTES=2, DATA_BYTES=1:
  - AA 34 12 7F 59 55 → addr=16'h1234, data=8'h7F.
  - Checksum 58 instead → err with err_code=1, err_count=1, no we.
- END byte 0x56 → err_code=0. Stop bit forced low in the DATA state → err_code=2. Line held idle for 33 bit-times after the 3rd byte → err_code=3. After all three, err_count=3.
- Drive reset low in the middle of the address bytes, release, send a valid frame → outputs are zero during reset and exactly one we follows for the new frame.
